// File: rtl/discr_scaler_counter.sv
// Scaler for discriminator edge hits: counts non-inhibited rising edges over a
// programmable period and latches each period total behind a valid/ack handshake.
module discr_scaler_counter #(
    parameter int P_N_WIDTH   = 32,
    parameter int P_CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             bits_in,
    input  logic [7:0]             inhibit_in,
    input  logic [P_N_WIDTH-1:0]   period_len,
    input  logic                   scaler_ack,
    output logic [P_CNT_WIDTH-1:0] scaler_cnt,
    output logic                   scaler_valid,
    output logic                   scaler_overrun,
    output logic                   scaler_sat
);

    logic [P_N_WIDTH-1:0]   len_r;
    logic [P_N_WIDTH-1:0]   pcnt;
    logic [P_CNT_WIDTH-1:0] acc;
    logic                   acc_ovf;
    logic                   prev_bit;

    logic [7:0]             edge_v;
    logic [7:0]             hit;
    logic [3:0]             add;
    logic [P_CNT_WIDTH:0]   sum_wide;
    logic [P_CNT_WIDTH-1:0] sum_sat;
    logic                   sum_ovf;
    logic                   dis;
    logic                   close;

    always_comb begin
        // Bit 0 compares against the newest sample of the previous word.
        edge_v = bits_in & ~{bits_in[6:0], prev_bit};
        hit    = edge_v & ~inhibit_in;
        add    = '0;
        for (int i = 0; i < 8; i++)
            add = add + {3'b000, hit[i]};
        sum_wide = {1'b0, acc} + {{(P_CNT_WIDTH-3){1'b0}}, add};
        // acc_ovf keeps the saturation flag sticky once acc has clipped.
        sum_ovf  = sum_wide[P_CNT_WIDTH] | acc_ovf;
        sum_sat  = sum_wide[P_CNT_WIDTH] ? '1 : sum_wide[P_CNT_WIDTH-1:0];
        dis      = (len_r == '0);
        close    = !dis && (pcnt >= len_r - P_N_WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_r          <= '0;
            prev_bit       <= 1'b0;
            pcnt           <= '0;
            acc            <= '0;
            acc_ovf        <= 1'b0;
            scaler_cnt     <= '0;
            scaler_valid   <= 1'b0;
            scaler_overrun <= 1'b0;
            scaler_sat     <= 1'b0;
        end else begin
            len_r    <= period_len;
            prev_bit <= bits_in[7];
            if (dis) begin
                pcnt           <= '0;
                acc            <= '0;
                acc_ovf        <= 1'b0;
                scaler_cnt     <= '0;
                scaler_valid   <= 1'b0;
                scaler_overrun <= 1'b0;
                scaler_sat     <= 1'b0;
            end else if (close) begin
                // Close beats a same-cycle ack; overwrite of an unread result is flagged.
                scaler_cnt     <= sum_sat;
                scaler_sat     <= sum_ovf;
                scaler_valid   <= 1'b1;
                scaler_overrun <= scaler_overrun | (scaler_valid & ~scaler_ack);
                acc            <= '0;
                acc_ovf        <= 1'b0;
                pcnt           <= '0;
            end else begin
                acc     <= sum_sat;
                acc_ovf <= sum_ovf;
                pcnt    <= pcnt + P_N_WIDTH'(1);
                if (scaler_ack)
                    scaler_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_discr_scaler_counter.sv
// Bench for discr_scaler_counter: 32-bit and 4-bit counter instances share
// stimulus and are checked every cycle against a period-level count model.
module tb_discr_scaler_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bits_in;
    logic [7:0]  inhibit_in;
    logic [31:0] period_len;
    logic        scaler_ack;

    logic [31:0] cnt32;
    logic        valid32, ovr32, sat32;
    logic [3:0]  cnt4;
    logic        valid4, ovr4, sat4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    discr_scaler_counter #(.P_N_WIDTH(32), .P_CNT_WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .bits_in(bits_in), .inhibit_in(inhibit_in),
        .period_len(period_len), .scaler_ack(scaler_ack),
        .scaler_cnt(cnt32), .scaler_valid(valid32),
        .scaler_overrun(ovr32), .scaler_sat(sat32));

    discr_scaler_counter #(.P_N_WIDTH(32), .P_CNT_WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .bits_in(bits_in), .inhibit_in(inhibit_in),
        .period_len(period_len), .scaler_ack(scaler_ack),
        .scaler_cnt(cnt4), .scaler_valid(valid4),
        .scaler_overrun(ovr4), .scaler_sat(sat4));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: true hit total per period, clipped to each width at readout.
    longint      m_len, m_pcnt, m_sum;
    logic        m_prev;
    longint      m_cnt32, m_cnt4;
    logic        m_sat32, m_sat4, m_valid, m_ovr;
    logic        started = 1'b0;
    int          m_add;
    longint      m_tot;
    logic        m_before;

    always @(posedge clk) begin
        m_add = 0;
        for (int i = 0; i < 8; i++) begin
            m_before = m_prev;
            if (i > 0) m_before = bits_in[i-1];
            if (bits_in[i] && !m_before && !inhibit_in[i]) m_add++;
        end
        if (rst || m_len == 0) begin
            m_pcnt = 0; m_sum = 0; m_cnt32 = 0; m_cnt4 = 0;
            m_sat32 = 0; m_sat4 = 0; m_valid = 0; m_ovr = 0;
            m_prev = rst ? 1'b0 : bits_in[7];
        end else begin
            m_tot = m_sum + m_add;
            if (m_pcnt >= m_len - 1) begin
                m_cnt32 = (m_tot > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_tot;
                m_sat32 = (m_tot > 64'hFFFF_FFFF);
                m_cnt4  = (m_tot > 15) ? 15 : m_tot;
                m_sat4  = (m_tot > 15);
                m_ovr   = m_ovr | (m_valid & !scaler_ack);
                m_valid = 1;
                m_sum   = 0;
                m_pcnt  = 0;
            end else begin
                m_sum  = m_tot;
                m_pcnt = m_pcnt + 1;
                if (scaler_ack) m_valid = 0;
            end
            m_prev = bits_in[7];
        end
        m_len   = rst ? 0 : longint'(period_len);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cnt32",   64'(cnt32),   64'(m_cnt32));
            chk("sat32",   64'(sat32),   64'(m_sat32));
            chk("valid32", 64'(valid32), 64'(m_valid));
            chk("ovr32",   64'(ovr32),   64'(m_ovr));
            chk("cnt4",    64'(cnt4),    64'(m_cnt4));
            chk("sat4",    64'(sat4),    64'(m_sat4));
            chk("valid4",  64'(valid4),  64'(m_valid));
            chk("ovr4",    64'(ovr4),    64'(m_ovr));
        end
    end

    // Apply one cycle of inputs; on return the outputs reflect that cycle.
    task automatic tick(input logic r, input logic [7:0] b, input logic [7:0] inh,
                        input logic [31:0] len, input logic ack);
        rst = r; bits_in = b; inhibit_in = inh; period_len = len; scaler_ack = ack;
        @(posedge clk);
        #2;
    endtask

    logic [31:0] lens [7];

    initial begin
        rst = 1'b1; bits_in = '0; inhibit_in = '0; period_len = '0; scaler_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_cnt",   64'(cnt32),   64'd0);
        chk("reset_valid", 64'(valid32), 64'd0);

        // Alternating single-edge words, period 4
        tick(1, 8'h00, 8'h00, 4, 0);
        for (int k = 0; k < 16; k++) tick(0, (k % 2 == 0) ? 8'h01 : 8'h00, 8'h00, 4, 0);
        chk("t1_cnt",   64'(cnt32),   64'd2);
        chk("t1_valid", 64'(valid32), 64'd1);

        // 0x55 constant, period 2
        tick(1, 8'h00, 8'h00, 2, 0);
        for (int k = 0; k < 7; k++) tick(0, 8'h55, 8'h00, 2, 0);
        chk("t2_cnt", 64'(cnt32), 64'd8);

        // Inhibit masking, period 1
        tick(1, 8'h00, 8'h00, 1, 0);
        tick(0, 8'h00, 8'h00, 1, 0);
        tick(0, 8'hF0, 8'h10, 1, 0);
        chk("t3_masked", 64'(cnt32), 64'd0);
        tick(0, 8'hF0, 8'hE0, 1, 0);
        chk("t3_unmasked", 64'(cnt32), 64'd1);

        // Word-boundary edge via prev_bit
        tick(0, 8'h80, 8'h00, 1, 0);
        tick(0, 8'h01, 8'h00, 1, 0);
        chk("t4_noedge", 64'(cnt32), 64'd0);
        tick(0, 8'h00, 8'h00, 1, 0);
        tick(0, 8'h01, 8'h00, 1, 0);
        chk("t4_edge", 64'(cnt32), 64'd1);

        // Handshake: ack on close, then overwrite without ack
        tick(1, 8'h00, 8'h00, 1, 0);
        tick(0, 8'h00, 8'h00, 1, 0);
        tick(0, 8'h01, 8'h00, 1, 0);
        tick(0, 8'h01, 8'h00, 1, 1);
        chk("t5_ackclose_valid", 64'(valid32), 64'd1);
        chk("t5_ackclose_ovr",   64'(ovr32),   64'd0);
        tick(0, 8'h05, 8'h00, 1, 0);
        chk("t5_ovr", 64'(ovr32), 64'd1);
        chk("t5_cnt", 64'(cnt32), 64'd2);
        // Ack alone on a non-close cycle
        tick(1, 8'h00, 8'h00, 5, 0);
        tick(0, 8'h00, 8'h00, 5, 0);
        for (int k = 0; k < 5; k++) tick(0, 8'h01, 8'h00, 5, 0);
        chk("t5_cnt5",  64'(cnt32),   64'd5);
        chk("t5_valid", 64'(valid32), 64'd1);
        tick(0, 8'h00, 8'h00, 5, 1);
        chk("t5_ack_clear", 64'(valid32), 64'd0);

        // Saturation on the 4-bit instance, then disable
        tick(1, 8'h00, 8'h00, 8, 0);
        tick(0, 8'h00, 8'h00, 8, 0);
        for (int k = 0; k < 8; k++) tick(0, 8'h55, 8'h00, 8, 0);
        chk("t6_cnt4",  64'(cnt4),  64'd15);
        chk("t6_sat4",  64'(sat4),  64'd1);
        chk("t6_cnt32", 64'(cnt32), 64'd32);
        chk("t6_sat32", 64'(sat32), 64'd0);
        tick(0, 8'h55, 8'h00, 0, 0);
        tick(0, 8'h55, 8'h00, 0, 0);
        chk("t6_dis_cnt",   64'(cnt4),   64'd0);
        chk("t6_dis_sat",   64'(sat4),   64'd0);
        chk("t6_dis_valid", 64'(valid4), 64'd0);
        // Reset in the middle of a period
        tick(0, 8'h00, 8'h00, 3, 0);
        tick(0, 8'h01, 8'h00, 3, 0);
        tick(0, 8'h00, 8'h00, 3, 0);
        tick(1, 8'h01, 8'h00, 3, 0);
        for (int k = 0; k < 8; k++) tick(0, (k % 2 == 0) ? 8'h01 : 8'h00, 8'h00, 3, 0);

        // Randomized traffic
        lens[0] = 0; lens[1] = 1; lens[2] = 2; lens[3] = 3; lens[4] = 5; lens[5] = 8; lens[6] = 13;
        period_len = 3;
        for (int k = 0; k < 4000; k++) begin
            logic [31:0] l;
            l = period_len;
            if ($urandom_range(0, 99) == 0) l = lens[$urandom_range(0, 6)];
            tick(($urandom_range(0, 199) == 0), 8'($urandom), ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom),
                 l, ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
